// File: rtl/pipelined_proc_param_if.sv
// rtl/pipelined_proc_param_if.sv - instruction-memory and retirement bus of the parametrised pipelined core
interface pipelined_proc_param_if #(
    parameter int DW   = 8,
    parameter int RB   = 3,
    parameter int IMMW = 3,
    parameter int PCW  = 8
);
    localparam int IW = 2 + RB + IMMW;

    logic [PCW-1:0] imem_addr;
    logic [IW-1:0]  imem_rdata;
    logic           imem_valid;
    logic [IW-1:0]  instr;
    logic [DW-1:0]  r_val;
    logic           wb_valid;
    logic [RB-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;

    modport master (
        output imem_addr, instr, r_val, wb_valid, wb_rd, wb_data,
        input  imem_rdata, imem_valid
    );

    modport slave (
        input  imem_addr, instr, r_val, wb_valid, wb_rd, wb_data,
        output imem_rdata, imem_valid
    );
endinterface

// File: rtl/pipelined_proc_param.sv
// rtl/pipelined_proc_param.sv - 4-stage IF/ID/EX/WB core with WB forwarding, EX-resolved BZ; PPROC_PERF_CNT_EN adds retire/flush counters
module pipelined_proc_param #(
    parameter int DW   = 8,
    parameter int RB   = 3,
    parameter int IMMW = 3,
    parameter int PCW  = 8
) (
    input  logic clk,
    input  logic reset,
    pipelined_proc_param_if.master bus
`ifdef PPROC_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int IW   = 2 + RB + IMMW;
    localparam int NREG = 1 << RB;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_BZ  = 2'b11;

    logic [PCW-1:0] pc;
    logic [DW-1:0]  regFile [NREG];

    // IF/ID
    logic           ifidValid;
    logic [IW-1:0]  ifidInstr;
    logic [PCW-1:0] ifidPc;

    // ID/EX
    logic           idexValid;
    logic [1:0]     idexOp;
    logic [RB-1:0]  idexRd;
    logic [IMMW-1:0] idexImm;
    logic [PCW-1:0] idexPc;
    logic [DW-1:0]  idexOperand;

    // EX/WB
    logic           exwbValid;
    logic [1:0]     exwbOp;
    logic [RB-1:0]  exwbRd;
    logic [DW-1:0]  exwbData;

    logic [1:0]     fetchOp;
    logic [PCW-1:0] fetchImmPc;
    logic [RB-1:0]  idRd;
    logic [DW-1:0]  idOperand;
    logic           wbWrites;
    logic [DW-1:0]  exOperand;
    logic [DW-1:0]  exImm;
    logic [DW-1:0]  aluResult;
    logic [DW-1:0]  rVal;
    logic           branchTaken;
    logic [PCW-1:0] branchTarget;

    // Fetch decode, forwarding muxes, ALU and branch resolution
    always_comb begin
        fetchOp    = bus.imem_rdata[IW-1 -: 2];
        fetchImmPc = PCW'($signed(bus.imem_rdata[IMMW-1:0]));

        // Only MOV and ADD update the register file; JMP/BZ retire without a write.
        wbWrites = exwbValid && ((exwbOp == OP_MOV) || (exwbOp == OP_ADD));

        idRd      = ifidInstr[RB+IMMW-1:IMMW];
        idOperand = (wbWrites && (exwbRd == idRd)) ? exwbData : regFile[idRd];

        exOperand = (wbWrites && (exwbRd == idexRd)) ? exwbData : idexOperand;
        exImm     = DW'($signed(idexImm));
        aluResult = (idexOp == OP_MOV) ? exImm : exOperand + exImm;
        rVal      = idexValid ? aluResult : '0;

        branchTaken  = idexValid && (idexOp == OP_BZ) && (exOperand == '0);
        branchTarget = idexPc + PCW'($signed(idexImm));
    end

    assign bus.imem_addr = pc;
    assign bus.instr     = bus.imem_valid ? bus.imem_rdata : '0;
    assign bus.r_val     = rVal;
    assign bus.wb_valid  = exwbValid;
    assign bus.wb_rd     = exwbRd;
    assign bus.wb_data   = exwbData;

    // PC update and IF/ID capture; a taken BZ overrides any JMP being fetched
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc        <= '0;
            ifidValid <= 1'b0;
            ifidInstr <= '0;
            ifidPc    <= '0;
        end else begin
            if (branchTaken) begin
                pc        <= branchTarget;
                ifidValid <= 1'b0;
            end else if (bus.imem_valid) begin
                pc        <= (fetchOp == OP_JMP) ? pc + fetchImmPc : pc + PCW'(1);
                ifidValid <= 1'b1;
            end else begin
                ifidValid <= 1'b0;
            end
            if (bus.imem_valid) begin
                ifidInstr <= bus.imem_rdata;
                ifidPc    <= pc;
            end
        end
    end

    // ID/EX capture; the slot in ID is squashed by a taken BZ
    always_ff @(posedge clk) begin
        if (!reset) begin
            idexValid   <= 1'b0;
            idexOp      <= '0;
            idexRd      <= '0;
            idexImm     <= '0;
            idexPc      <= '0;
            idexOperand <= '0;
        end else begin
            idexValid   <= ifidValid && !branchTaken;
            idexOp      <= ifidInstr[IW-1 -: 2];
            idexRd      <= idRd;
            idexImm     <= ifidInstr[IMMW-1:0];
            idexPc      <= ifidPc;
            idexOperand <= idOperand;
        end
    end

    // EX/WB capture feeding the retirement outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            exwbValid <= 1'b0;
            exwbOp    <= '0;
            exwbRd    <= '0;
            exwbData  <= '0;
        end else begin
            exwbValid <= idexValid;
            exwbOp    <= idexOp;
            exwbRd    <= idexRd;
            exwbData  <= rVal;
        end
    end

    // Register file write at the end of the WB cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbWrites) begin
            regFile[exwbRd] <= exwbData;
        end
    end

`ifdef PPROC_PERF_CNT_EN
    // Retirement and taken-branch counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (exwbValid) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (branchTaken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: doc/pipelined_proc_param.md
Name: pipelined_proc_param

Overview:
- Parametrised successor of the team's 8-bit forwarding pipelined core; data width, register count, immediate width and PC width are configurable.
- Four stages: IF, ID (register read), EX (ALU and branch resolution), WB (register write).
- Adds an external instruction-memory handshake with fetch bubbles, and a conditional branch resolved in EX with a 2-instruction flush.
- Forwarding is from WB to both ID and EX.

Parameters:
- DW, 8: data and register width.
- RB, 3: register index bits; NREG = 2^RB registers.
- IMMW, 3: immediate width, sign-extended.
- PCW, 8: PC and instruction-address width.
- Derived localparam IW = 2 + RB + IMMW. Encoding: op[IW-1:IW-2], rd[RB+IMMW-1:IMMW], imm[IMMW-1:0].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  PCW  fetch address; this is the current PC.
- imem_rdata  in  IW  instruction at imem_addr, read combinationally in the same cycle.
- imem_valid  in  1  imem_rdata is valid this cycle.
- instr  out  IW  instruction accepted by IF this cycle; 0 when a bubble is inserted.
- r_val  out  DW  EX-stage ALU result.
- wb_valid  out  1  an instruction retires this cycle.
- wb_rd  out  RB  destination register of the retiring instruction.
- wb_data  out  DW  value written by the retiring instruction.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset; it is sampled only at the clk rising edge.
- Reset values: PC=0; all stage valid bits=0; all registers=0; r_val, wb_rd and wb_data=0; wb_valid=0. A mid-run reset discards all in-flight instructions, with no writes.
- Opcodes (imm sign-extended to DW for data ops, to PCW for PC ops):
  - 00 MOV: rd = sext(imm).
  - 01 ADD: rd = rd + sext(imm), modulo 2^DW.
  - 10 JMP: PC += sext(imm); resolved in IF; no write.
  - 11 BZ: if rd == 0 then PC = pc_of_BZ + sext(imm); resolved in EX; no write.
- All PC arithmetic wraps modulo 2^PCW.
- IF stage:
  - imem_valid=1: capture the instruction and its PC into IF/ID. PC advances to PC+1, or PC+sext(imm) for JMP.
  - imem_valid=0: PC holds and a bubble (valid=0) enters IF/ID.
- ID stage:
  - Reads rd from the register file.
  - If WB is valid, writes, and wb_rd==rd, wb_data is used instead of the array value (write-through).
- EX stage:
  - Operand = wb_data if WB is valid, writes, and wb_rd==rd; otherwise the value captured in ID/EX.
  - r_val is driven with the ALU result every cycle; it is 0 for a bubble.
- WB stage: the register file is written at the clk edge ending the WB cycle, for MOV and ADD only.
- Latency: an instruction accepted in cycle n is in EX at n+2 and has wb_valid=1 at n+3. Back-to-back dependent instructions run without stalls.
- BZ taken in EX:
  - PC is loaded with the target.
  - The IF/ID and ID/EX contents captured at this edge are invalidated, which squashes 2 younger slots.
- BZ not taken: no effect on the pipeline.
- Simultaneous events:
  - A taken BZ in EX and a JMP in IF in the same cycle: BZ wins and the JMP is squashed.
  - A taken BZ while imem_valid=0: the redirect still occurs.
- Squashed instructions and bubbles never assert wb_valid and never write registers.

Optional Feature:
- Macro PPROC_PERF_CNT_EN.
- When defined: adds ports retired_cnt (out, 32) and flush_cnt (out, 32).
  - Both reset to 0.
  - retired_cnt increments on each valid instruction leaving WB, including JMP and BZ.
  - flush_cnt increments by 1 per taken BZ.
  - Both wrap modulo 2^32.
- When undefined: neither port exists and no counter logic is built.

Test Plan (defaults, IW=8):
1. Hold reset low 3 cycles with imem_valid=1, then release -> during reset imem_addr=0, wb_valid=0, r_val=0; the first fetch after release is at address 0.
2. Forwarding: program 0x0B (MOV r1,3), 0x4A (ADD r1,2), 0x4F (ADD r1,-1) -> wb_data 3, 5, 4 on three consecutive cycles, wb_rd=1 each, with no bubble between them.
3. JMP: 0x83 at address 0 -> imem_addr sequence 0, 3, 4; the JMP's retirement writes no register.
4. BZ taken: 0x10 (MOV r2,0) at address 0, 0xD2 (BZ r2,+2) at address 1 -> imem_addr 0, 1, 2, 3, 3; the instructions fetched from address 2 and the first fetch of address 3 never assert wb_valid.
5. Wrap and forwarding: 0x1F (MOV r3,-1), 0x59 (ADD r3,1), 0xDB (BZ r3,+3) -> wb_data 0xFF then 0x00; BZ is taken using the forwarded 0; PC wraps correctly when the target exceeds 255.
6. Drop imem_valid for 2 cycles mid-program -> imem_addr holds for 2 cycles; instr=0 for those cycles; wb_valid is low for exactly 2 cycles three cycles later; register results are unchanged versus a run without the stall.
